// File: rtl/pulse_catch_sync.sv
// pulse_catch_sync
//   Multi-channel pulse-catching synchroniser. Each channel catches an
//   active edge on an asynchronous input, however narrow, in a capture flop.
//   It carries that edge into the clock domain through a STAGES-deep chain
//   and turns it into one single-cycle event pulse. Each pulse also advances
//   a saturating per-channel event counter.
//
// Parameters
//   CHANNELS : number of independent channels (>= 1)
//   STAGES   : synchroniser flops after the capture flop (>= 2)
//   EDGE     : active edge, 0 = rising, 1 = falling
//   COUNT_W  : per-channel event counter width (>= 1)
//
// Ports
//   clock        : system clock, all outputs synchronous to its rising edge
//   reset        : asynchronous active-high reset
//   async_in     : asynchronous event inputs, one bit per channel
//   count_clr    : synchronous clear of all event counters
//   sync_level   : synchronised capture state (last sync stage)
//   sync_pulse   : one-cycle pulse per captured event
//   count        : saturating counts, channel i at [i*COUNT_W +: COUNT_W]
module pulse_catch_sync #(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 2,
  parameter int EDGE     = 0,
  parameter int COUNT_W  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           async_in,
  input  logic                          count_clr,
  output logic [CHANNELS-1:0]           sync_level,
  output logic [CHANNELS-1:0]           sync_pulse,
  output logic [CHANNELS*COUNT_W-1:0]   count
);

  // Inverting the input for falling-edge mode makes every channel look
  // like a rising-edge catcher from here on.
  localparam logic EDGE_BIT = (EDGE != 0);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic               w_act;      // input at its active level
      logic               w_cap_rst;  // asynchronous clear of the capture flop
      logic               r_cap;
      logic [STAGES-1:0]  r_sync;
      logic               r_d;
      logic               w_pulse;
      logic [COUNT_W-1:0] r_count;

      assign w_act = async_in[i] ^ EDGE_BIT;

      // The capture flop is released only once the event is visible at the
      // end of the chain and the input is back at its inactive level. So a
      // held input cannot retrigger, and reset holds the flop clear.
      assign w_cap_rst = reset | (r_sync[STAGES-1] & ~w_act);

      always_ff @(posedge w_act or posedge w_cap_rst) begin
        if (w_cap_rst) r_cap <= 1'b0;
        else           r_cap <= 1'b1;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_sync <= '0;
          r_d    <= 1'b0;
        end else begin
          r_sync <= {r_sync[STAGES-2:0], r_cap};
          r_d    <= r_sync[STAGES-1];
        end
      end

      assign w_pulse = r_sync[STAGES-1] & ~r_d;

      // The clear takes priority, so an event coincident with a clear is dropped.
      always_ff @(posedge clock or posedge reset) begin
        if (reset)                                 r_count <= '0;
        else if (count_clr)                        r_count <= '0;
        else if (w_pulse && (r_count != COUNT_MAX)) r_count <= r_count + 1'b1;
      end

      assign sync_level[i]                  = r_sync[STAGES-1];
      assign sync_pulse[i]                  = w_pulse;
      assign count[i*COUNT_W +: COUNT_W]    = r_count;
    end
  endgenerate

endmodule

// File: tb/tb_pulse_catch_sync.sv
// tb_pulse_catch_sync
//   Bench for pulse_catch_sync. Three instances share clock and reset:
//   dut0 is rising-edge with 8-bit counters, dsat is rising-edge with
//   2-bit counters and dfall is falling-edge with 8-bit counters.
module tb_pulse_catch_sync;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in0     = '0;
  logic [3:0]  in_sat  = '0;
  logic [3:0]  in_fall = '1;
  logic        clr0 = 1'b0, clr_sat = 1'b0, clr_fall = 1'b0;
  logic [3:0]  lvl0, pls0, lvl_sat, pls_sat, lvl_fall, pls_fall;
  logic [31:0] cnt0, cnt_fall;
  logic [7:0]  cnt_sat;

  int errors = 0;
  int checks = 0;

  // Pulses seen on each output, gathered by the monitor.
  int pc0[4], pc_sat[4], pc_fall[4];
  // Reference model: events delivered to dut0 since the last clear or reset.
  int exp_cnt[4];

  pulse_catch_sync #(.CHANNELS(4), .STAGES(2), .EDGE(0), .COUNT_W(8)) dut0 (
    .clock(clock), .reset(reset), .async_in(in0), .count_clr(clr0),
    .sync_level(lvl0), .sync_pulse(pls0), .count(cnt0));

  pulse_catch_sync #(.CHANNELS(4), .STAGES(2), .EDGE(0), .COUNT_W(2)) dsat (
    .clock(clock), .reset(reset), .async_in(in_sat), .count_clr(clr_sat),
    .sync_level(lvl_sat), .sync_pulse(pls_sat), .count(cnt_sat));

  pulse_catch_sync #(.CHANNELS(4), .STAGES(2), .EDGE(1), .COUNT_W(8)) dfall (
    .clock(clock), .reset(reset), .async_in(in_fall), .count_clr(clr_fall),
    .sync_level(lvl_fall), .sync_pulse(pls_fall), .count(cnt_fall));

  // Clock and reset: 100 MHz; reset starts asserted and is released by test_reset.
  always #5 clock = ~clock;

  always @(negedge clock) begin
    for (int c = 0; c < 4; c++) begin
      if (pls0[c])     pc0[c]++;
      if (pls_sat[c])  pc_sat[c]++;
      if (pls_fall[c]) pc_fall[c]++;
    end
  end

  function automatic logic [31:0] model_bus();
    logic [31:0] b;
    b = '0;
    for (int c = 0; c < 4; c++)
      b[c*8 +: 8] = (exp_cnt[c] > 255) ? 8'd255 : exp_cnt[c][7:0];
    return b;
  endfunction

  // Driver: short high pulse on one dut0 channel, starting just after a falling clock edge.
  task automatic drive_pulse0(input int ch, input int width_ns);
    @(negedge clock);
    #1 in0[ch] = 1'b1;
    #(width_ns) in0[ch] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({lvl0, pls0, lvl_sat, pls_sat, lvl_fall, pls_fall} !== 24'd0) begin
      errors++;
      $display("FAIL reset_levels: got %h, expected 0",
               {lvl0, pls0, lvl_sat, pls_sat, lvl_fall, pls_fall});
    end
    checks++;
    if ({cnt0, cnt_sat, cnt_fall} !== 72'd0) begin
      errors++;
      $display("FAIL reset_counts: got %h, expected 0", {cnt0, cnt_sat, cnt_fall});
    end
    // An edge while reset is held must be ignored.
    #1 in0[2] = 1'b1;
    #2 in0[2] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    checks++;
    if (pc0[2] !== 0 || lvl0 !== 4'd0) begin
      errors++;
      $display("FAIL reset_edge_ignored: pulses=%0d level=%b, expected 0 and 0000",
               pc0[2], lvl0);
    end
  endtask

  task automatic test_narrow_pulse();
    int base[4];
    int lat;
    lat = -1;
    for (int c = 0; c < 4; c++) base[c] = pc0[c];
    drive_pulse0(1, 2);
    for (int n = 1; n <= 6 && lat < 0; n++) begin
      @(negedge clock);
      if (lvl0[1]) lat = n;
    end
    checks++;
    if (lat < 2 || lat > 3) begin
      errors++;
      $display("FAIL narrow_latency: got %0d edges, expected 2..3", lat);
    end
    repeat (10) @(negedge clock);
    exp_cnt[1]++;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (pc0[c] - base[c] !== ((c == 1) ? 1 : 0)) begin
        errors++;
        $display("FAIL narrow_pulses ch%0d: got %0d, expected %0d",
                 c, pc0[c] - base[c], (c == 1) ? 1 : 0);
      end
    end
    checks++;
    if (cnt0 !== model_bus()) begin
      errors++;
      $display("FAIL narrow_count: got %h, expected %h", cnt0, model_bus());
    end
  endtask

  task automatic test_long_level();
    int base;
    base = pc0[0];
    @(negedge clock);
    #1 in0[0] = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (lvl0[0] !== 1'b1) begin
      errors++;
      $display("FAIL long_level_held: got %b, expected 1", lvl0[0]);
    end
    #1 in0[0] = 1'b0;
    @(negedge clock);
    checks++;
    if (lvl0[0] !== 1'b1) begin
      errors++;
      $display("FAIL long_level_after_release: got %b, expected 1", lvl0[0]);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (lvl0[0] !== 1'b0) begin
      errors++;
      $display("FAIL long_level_cleared: got %b, expected 0", lvl0[0]);
    end
    exp_cnt[0]++;
    checks++;
    if (pc0[0] - base !== 1) begin
      errors++;
      $display("FAIL long_pulses: got %0d, expected 1", pc0[0] - base);
    end
    checks++;
    if (cnt0 !== model_bus()) begin
      errors++;
      $display("FAIL long_count: got %h, expected %h", cnt0, model_bus());
    end
  endtask

  task automatic test_saturation();
    int want;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      #1 in_sat[2] = 1'b1;
      #2 in_sat[2] = 1'b0;
      repeat (10) @(negedge clock);
      want = (k > 3) ? 3 : k;
      checks++;
      if (cnt_sat[5:4] !== want[1:0] || pc_sat[2] !== k) begin
        errors++;
        $display("FAIL saturation pulse %0d: count=%0d pulses=%0d, expected count=%0d pulses=%0d",
                 k, cnt_sat[5:4], pc_sat[2], want, k);
      end
    end
  endtask

  task automatic test_falling();
    @(negedge clock);
    #1 in_fall[0] = 1'b0;
    #3 in_fall[0] = 1'b1;
    repeat (10) @(negedge clock);
    checks++;
    if (pc_fall[0] !== 1 || cnt_fall !== 32'd1) begin
      errors++;
      $display("FAIL falling_glitch: pulses=%0d count=%h, expected 1 and 00000001",
               pc_fall[0], cnt_fall);
    end
    // A held low level, then the rising edge back to idle: only the fall counts.
    #1 in_fall[0] = 1'b0;
    repeat (10) @(negedge clock);
    #1 in_fall[0] = 1'b1;
    repeat (10) @(negedge clock);
    checks++;
    if (pc_fall[0] !== 2 || cnt_fall !== 32'd2 || lvl_fall !== 4'd0) begin
      errors++;
      $display("FAIL falling_level: pulses=%0d count=%h level=%b, expected 2, 00000002, 0000",
               pc_fall[0], cnt_fall, lvl_fall);
    end
  endtask

  task automatic test_clear_contention();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_pulse0(3, 2);
      repeat (10) @(negedge clock);
      exp_cnt[3]++;
    end
    checks++;
    if (cnt0[31:24] !== 8'd5) begin
      errors++;
      $display("FAIL clear_precount: got %0d, expected 5", cnt0[31:24]);
    end
    drive_pulse0(3, 2);
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clock);
      if (pls0[3]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL clear_pulse_timeout: got no pulse, expected one within 6 cycles");
    end
    clr0 = 1'b1;
    @(negedge clock);
    clr0 = 1'b0;
    for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
    checks++;
    if (cnt0 !== 32'd0) begin
      errors++;
      $display("FAIL clear_contention: got %h, expected 0", cnt0);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (cnt0 !== 32'd0) begin
      errors++;
      $display("FAIL clear_hold: got %h, expected 0", cnt0);
    end
  endtask

  task automatic test_random();
    int base[4];
    int events[4];
    logic [3:0] mask;
    int width;
    for (int c = 0; c < 4; c++) begin
      base[c] = pc0[c];
      events[c] = 0;
    end
    for (int it = 0; it < 16; it++) begin
      mask  = 4'($urandom_range(1, 15));
      width = $urandom_range(1, 40);
      @(negedge clock);
      #1 in0 = mask;
      #(width) in0 = 4'd0;
      repeat (12) @(negedge clock);
      for (int c = 0; c < 4; c++)
        if (mask[c]) begin
          events[c]++;
          exp_cnt[c]++;
        end
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (pc0[c] - base[c] !== events[c]) begin
        errors++;
        $display("FAIL random_pulses ch%0d: got %0d, expected %0d",
                 c, pc0[c] - base[c], events[c]);
      end
    end
    checks++;
    if (cnt0 !== model_bus()) begin
      errors++;
      $display("FAIL random_counts: got %h, expected %h", cnt0, model_bus());
    end
  endtask

  task automatic test_reset_midflight();
    int base;
    base = pc0[0];
    drive_pulse0(0, 2);
    @(negedge clock);
    #1 reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      checks++;
      if (lvl0 !== 4'd0 || pls0 !== 4'd0 || cnt0 !== 32'd0) begin
        errors++;
        $display("FAIL midflight_during_reset: level=%b pulse=%b count=%h, expected all 0",
                 lvl0, pls0, cnt0);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
    repeat (10) @(negedge clock);
    checks++;
    if (pc0[0] !== base || lvl0 !== 4'd0 || cnt0 !== model_bus()) begin
      errors++;
      $display("FAIL midflight_after_reset: pulses=%0d level=%b count=%h, expected %0d, 0000, %h",
               pc0[0], lvl0, cnt0, base, model_bus());
    end
  endtask

  initial begin
    test_reset();
    test_narrow_pulse();
    test_long_level();
    test_saturation();
    test_falling();
    test_clear_contention();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors == 0) $display("PASS");
    else             $display("FAIL");
    $finish;
  end

endmodule
